// File: rtl/axi_m2s_arbiter_pkg.sv
// axi_arb_pkg: FSM state encodings and default widths shared by the AXI master-to-slave arbiter.
package axi_arb_pkg;
  localparam int DEF_NUM_M     = 2;
  localparam int DEF_ID_BITS   = 4;
  localparam int DEF_ADDR_BITS = 32;
  localparam int DEF_DATA_BITS = 32;
  localparam int DEF_LEN_BITS  = 4;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} w_state_e;
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_m2s_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, scanning upward from ptr_i with wrap.
module rr_arbiter import axi_arb_pkg::*; #(
  parameter int N  = 2,
  parameter int IW = idx_bits(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + i) % N);
      end
    end
    gnt_o[idx_o] = valid_o;
  end
endmodule

// File: rtl/axi_m2s_arbiter.sv
// axi_m2s_arbiter: round-robin AR and AW/W arbitration, grant held until last R beat or B handshake.
module axi_m2s_arbiter import axi_arb_pkg::*; #(
  parameter int NUM_M     = DEF_NUM_M,
  parameter int ID_BITS   = DEF_ID_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int LEN_BITS  = DEF_LEN_BITS
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_M*ID_BITS-1:0]        ARID_M,
  input  logic [NUM_M*ADDR_BITS-1:0]      ARADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]       ARLEN_M,
  input  logic [NUM_M*3-1:0]              ARSIZE_M,
  input  logic [NUM_M*2-1:0]              ARBURST_M,
  input  logic [NUM_M-1:0]                ARVALID_M,
  input  logic [NUM_M*ID_BITS-1:0]        AWID_M,
  input  logic [NUM_M*ADDR_BITS-1:0]      AWADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]       AWLEN_M,
  input  logic [NUM_M*3-1:0]              AWSIZE_M,
  input  logic [NUM_M*2-1:0]              AWBURST_M,
  input  logic [NUM_M-1:0]                AWVALID_M,
  input  logic [NUM_M*DATA_BITS-1:0]      WDATA_M,
  input  logic [NUM_M*(DATA_BITS/8)-1:0]  WSTRB_M,
  input  logic [NUM_M-1:0]                WLAST_M,
  input  logic [NUM_M-1:0]                WVALID_M,
  input  logic [NUM_M-1:0]                RREADY_M,
  input  logic [NUM_M-1:0]                BREADY_M,
  input  logic                            ARREADY,
  input  logic                            AWREADY,
  input  logic                            WREADY,
  input  logic                            RVALID,
  input  logic                            RLAST,
  input  logic                            BVALID,
  output logic [ID_BITS-1:0]              ARID,
  output logic [ADDR_BITS-1:0]            ARADDR,
  output logic [LEN_BITS-1:0]             ARLEN,
  output logic [2:0]                      ARSIZE,
  output logic [1:0]                      ARBURST,
  output logic                            ARVALID,
  output logic [ID_BITS-1:0]              AWID,
  output logic [ADDR_BITS-1:0]            AWADDR,
  output logic [LEN_BITS-1:0]             AWLEN,
  output logic [2:0]                      AWSIZE,
  output logic [1:0]                      AWBURST,
  output logic                            AWVALID,
  output logic [DATA_BITS-1:0]            WDATA,
  output logic [DATA_BITS/8-1:0]          WSTRB,
  output logic                            WLAST,
  output logic                            WVALID,
  output logic                            RREADY,
  output logic                            BREADY,
  output logic [NUM_M-1:0]                GRANT_R,
  output logic [NUM_M-1:0]                GRANT_W
);
  localparam int IW = idx_bits(NUM_M);
  localparam int SB = DATA_BITS / 8;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_M - 1)) ? '0 : i + 1'b1;
  endfunction
  r_state_e         r_state_q, r_state_d;
  w_state_e         w_state_q, w_state_d;
  logic [IW-1:0]    r_idx_q, r_idx_d, r_ptr_q, r_ptr_d, r_win_idx;
  logic [IW-1:0]    w_idx_q, w_idx_d, w_ptr_q, w_ptr_d, w_win_idx;
  logic [NUM_M-1:0] r_gnt_q, r_gnt_d, r_win_gnt, w_gnt_q, w_gnt_d, w_win_gnt;
  logic             r_win_vld, w_win_vld;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             r_addr, r_data, aw_on, w_on, w_resp;
  rr_arbiter #(.N(NUM_M)) u_rr_r (.req_i(ARVALID_M), .ptr_i(r_ptr_q), .gnt_o(r_win_gnt), .idx_o(r_win_idx), .valid_o(r_win_vld));
  rr_arbiter #(.N(NUM_M)) u_rr_w (.req_i(AWVALID_M), .ptr_i(w_ptr_q), .gnt_o(w_win_gnt), .idx_o(w_win_idx), .valid_o(w_win_vld));
  assign r_addr  = r_state_q == R_ADDR;
  assign r_data  = r_state_q == R_DATA;
  assign aw_on   = (w_state_q == W_ADDR) && !aw_done_q;
  assign w_on    = (w_state_q == W_ADDR) && !w_done_q;
  assign w_resp  = w_state_q == W_RESP;
  assign ARID    = r_addr ? ARID_M[r_idx_q*ID_BITS +: ID_BITS] : '0;
  assign ARADDR  = r_addr ? ARADDR_M[r_idx_q*ADDR_BITS +: ADDR_BITS] : '0;
  assign ARLEN   = r_addr ? ARLEN_M[r_idx_q*LEN_BITS +: LEN_BITS] : '0;
  assign ARSIZE  = r_addr ? ARSIZE_M[r_idx_q*3 +: 3] : '0;
  assign ARBURST = r_addr ? ARBURST_M[r_idx_q*2 +: 2] : '0;
  assign ARVALID = r_addr && ARVALID_M[r_idx_q];
  assign RREADY  = r_data && RREADY_M[r_idx_q];
  assign AWID    = aw_on ? AWID_M[w_idx_q*ID_BITS +: ID_BITS] : '0;
  assign AWADDR  = aw_on ? AWADDR_M[w_idx_q*ADDR_BITS +: ADDR_BITS] : '0;
  assign AWLEN   = aw_on ? AWLEN_M[w_idx_q*LEN_BITS +: LEN_BITS] : '0;
  assign AWSIZE  = aw_on ? AWSIZE_M[w_idx_q*3 +: 3] : '0;
  assign AWBURST = aw_on ? AWBURST_M[w_idx_q*2 +: 2] : '0;
  assign AWVALID = aw_on && AWVALID_M[w_idx_q];
  assign WDATA   = w_on ? WDATA_M[w_idx_q*DATA_BITS +: DATA_BITS] : '0;
  assign WSTRB   = w_on ? WSTRB_M[w_idx_q*SB +: SB] : '0;
  assign WLAST   = w_on && WLAST_M[w_idx_q];
  assign WVALID  = w_on && WVALID_M[w_idx_q];
  assign BREADY  = w_resp && BREADY_M[w_idx_q];
  assign GRANT_R = r_gnt_q;
  assign GRANT_W = w_gnt_q;
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_ptr_d   = r_ptr_q;
    r_gnt_d   = r_gnt_q;
    if (r_state_q == R_IDLE && r_win_vld) begin
      r_state_d = R_ADDR;
      r_idx_d   = r_win_idx;
      r_gnt_d   = r_win_gnt;
    end
    if (r_addr && ARVALID && ARREADY) r_state_d = R_DATA;
    if (r_data && RVALID && RREADY && RLAST) begin
      r_state_d = R_IDLE;
      r_ptr_d   = inc(r_idx_q);
      r_gnt_d   = '0;
    end
  end
  // AW and W finish independently; either sticky flag may land first.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_ptr_d   = w_ptr_q;
    w_gnt_d   = w_gnt_q;
    aw_done_d = aw_done_q | (AWVALID & AWREADY);
    w_done_d  = w_done_q | (WVALID & WREADY & WLAST);
    if (w_state_q == W_IDLE && w_win_vld) begin
      w_state_d = W_ADDR;
      w_idx_d   = w_win_idx;
      w_gnt_d   = w_win_gnt;
    end
    if (w_state_q == W_ADDR && aw_done_d && w_done_d) w_state_d = W_RESP;
    if (w_resp && BVALID && BREADY) begin
      w_state_d = W_IDLE;
      w_ptr_d   = inc(w_idx_q);
      w_gnt_d   = '0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      r_idx_q   <= '0;
      r_ptr_q   <= '0;
      r_gnt_q   <= '0;
      w_idx_q   <= '0;
      w_ptr_q   <= '0;
      w_gnt_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_idx_q   <= r_idx_d;
      r_ptr_q   <= r_ptr_d;
      r_gnt_q   <= r_gnt_d;
      w_idx_q   <= w_idx_d;
      w_ptr_q   <= w_ptr_d;
      w_gnt_q   <= w_gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule
